// File: rtl/csi2_test_pattern_gen_if.sv
// Pixel-side bus from the test-pattern source to the pixel-to-byte converter.
// Latency: n/a (wires only); all signals are driven from registers in the master.
// Backpressure: none; the converter must accept every cycle the master drives.
interface csi2_test_pattern_gen_if #(
  parameter int PIX_WIDTH    = 10,
  parameter int NUM_PIX_LANE = 1
);
  logic                              fv_o;
  logic                              lv_o;
  logic                              dvalid_o;
  logic [PIX_WIDTH*NUM_PIX_LANE-1:0] pixdata_o;

  modport master (output fv_o, lv_o, dvalid_o, pixdata_o);
  modport slave  (input  fv_o, lv_o, dvalid_o, pixdata_o);
endinterface

// File: rtl/csi2_test_pattern_gen.sv
// Frame-timing sequencer and test-pattern source standing in for a camera sensor.
// Latency: enable & synced init-done seen at edge N gives fv/busy after edge N+1; init-done sync is 2 flops.
// Backpressure: none; free-running once a frame starts, frames are never truncated.
module csi2_test_pattern_gen #(
  parameter int PIX_WIDTH    = 10,
  parameter int NUM_PIX_LANE = 1,
  parameter int H_ACTIVE     = 160,
  parameter int H_BLANK      = 40,
  parameter int V_ACTIVE     = 120,
  parameter int V_FRONT      = 16,
  parameter int V_BACK       = 16,
  parameter int V_BLANK      = 64
) (
  input  logic                    pix_clk_i,
  input  logic                    reset_n_i,
  input  logic                    enable_i,
  input  logic                    tinit_done_i,
  input  logic [1:0]              pattern_i,
  csi2_test_pattern_gen_if.master pix,
  output logic [15:0]             frame_cnt_o,
  output logic                    busy_o
);
  localparam int DW      = PIX_WIDTH * NUM_PIX_LANE;
  localparam int BAR_LEN = H_ACTIVE / 8;
  localparam int MAX_A   = (V_FRONT > H_BLANK) ? V_FRONT : H_BLANK;
  localparam int MAX_B   = (V_BACK > V_BLANK) ? V_BACK : V_BLANK;
  localparam int MAX_D   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_D + 1);
  // x and y keep at least 4 bits so the checkerboard can always use bit 3.
  localparam int XW      = ($clog2(H_ACTIVE) > 4) ? $clog2(H_ACTIVE) : 4;
  localparam int YW      = ($clog2(V_ACTIVE) > 4) ? $clog2(V_ACTIVE) : 4;
  localparam int SW      = $clog2(BAR_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FV_LEAD, S_LINE, S_HBLANK, S_FV_TRAIL, S_VBLANK
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [XW-1:0]        x, nx;
  logic [YW-1:0]        y;
  logic [2:0]           bar, nbar;
  logic [SW-1:0]        sub, nsub;
  logic [1:0]           pattern_q;
  logic [1:0]           sync;
  logic                 rdy, start, frame_go, line_first, line_load;
  logic                 fv_q, lv_q;
  logic [DW-1:0]        pix_q, pix_next;
  logic [PIX_WIDTH-1:0] lane;

  assign rdy   = sync[1];
  assign start = enable_i & rdy;

  // A frame may only begin from idle or at the very end of vertical blanking.
  assign frame_go   = start & ((state == S_IDLE) |
                               ((state == S_VBLANK) & (cnt == CW'(V_BLANK - 1))));
  // The next cycle is the first active cycle of a line.
  assign line_first = ((state == S_FV_LEAD) & (cnt == CW'(V_FRONT - 1))) |
                      ((state == S_HBLANK)  & (cnt == CW'(H_BLANK - 1)));
  // The next cycle is an active cycle (first or continuing).
  assign line_load  = line_first | ((state == S_LINE) & (x != XW'(H_ACTIVE - 1)));

  assign pix.fv_o      = fv_q;
  assign pix.lv_o      = lv_q;
  assign pix.dvalid_o  = lv_q;
  assign pix.pixdata_o = pix_q;

  // Two-flop synchronizer for the asynchronous D-PHY init-done flag.
  always_ff @(posedge pix_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) sync <= 2'b00;
    else            sync <= {sync[0], tinit_done_i};
  end

  // Position of the next active cycle; bar advances every BAR_LEN cycles without a divider.
  always_comb begin
    nx   = '0;
    nbar = '0;
    nsub = '0;
    if (!line_first) begin
      nx = x + 1'b1;
      if (sub == SW'(BAR_LEN - 1)) begin
        nbar = bar + 1'b1;
      end else begin
        nbar = bar;
        nsub = sub + 1'b1;
      end
    end
  end

  // Pixel value for the next active cycle, one lane slice at a time.
  always_comb begin
    pix_next = '0;
    lane     = '0;
    for (int k = 0; k < NUM_PIX_LANE; k++) begin
      case (pattern_q)
        2'd0:    lane = PIX_WIDTH'(32'(nx) * NUM_PIX_LANE + k);
        2'd1:    lane = PIX_WIDTH'(y);
        2'd2:    lane = PIX_WIDTH'(32'(nbar) << (PIX_WIDTH - 3));
        default: lane = {PIX_WIDTH{nx[3] ^ y[3] ^ frame_cnt_o[0]}};
      endcase
      pix_next[k*PIX_WIDTH +: PIX_WIDTH] = lane;
    end
  end

  // Frame sequencer: state, counters and all registered outputs move together.
  always_ff @(posedge pix_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      x           <= '0;
      y           <= '0;
      bar         <= '0;
      sub         <= '0;
      pattern_q   <= '0;
      fv_q        <= 1'b0;
      lv_q        <= 1'b0;
      pix_q       <= '0;
      frame_cnt_o <= '0;
      busy_o      <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (line_load) begin
        x     <= nx;
        bar   <= nbar;
        sub   <= nsub;
        pix_q <= pix_next;
      end else begin
        pix_q <= '0;
      end
      if (frame_go) begin
        state     <= S_FV_LEAD;
        cnt       <= '0;
        y         <= '0;
        pattern_q <= pattern_i;
        fv_q      <= 1'b1;
        busy_o    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
          end
          S_FV_LEAD, S_HBLANK: begin
            if (line_first) begin
              state <= S_LINE;
              lv_q  <= 1'b1;
            end
          end
          S_LINE: begin
            if (!line_load) begin
              lv_q <= 1'b0;
              cnt  <= '0;
              if (y == YW'(V_ACTIVE - 1)) begin
                state <= S_FV_TRAIL;
              end else begin
                state <= S_HBLANK;
                y     <= y + 1'b1;
              end
            end
          end
          S_FV_TRAIL: begin
            if (cnt == CW'(V_BACK - 1)) begin
              state       <= S_VBLANK;
              cnt         <= '0;
              fv_q        <= 1'b0;
              frame_cnt_o <= frame_cnt_o + 1'b1;
            end
          end
          S_VBLANK: begin
            if (cnt == CW'(V_BLANK - 1)) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end
          end
          default: begin
            state  <= S_IDLE;
            fv_q   <= 1'b0;
            lv_q   <= 1'b0;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_csi2_test_pattern_gen.sv
// Bench for the CSI-2 test-pattern generator: one single-lane and one dual-lane instance.
// Both share stimulus; a frame-position reference model predicts every output each cycle.
// Directed phases measure frame timing, pattern latching, enable drop and mid-frame reset.
module tb_csi2_test_pattern_gen;
  localparam int PW    = 10;
  localparam int HA    = 16;
  localparam int HB    = 4;
  localparam int VA    = 3;
  localparam int VF    = 2;
  localparam int VBK   = 3;
  localparam int VBL   = 5;
  localparam int LP    = HA + HB;
  localparam int FVH   = VF + VA*HA + (VA-1)*HB + VBK;
  localparam int PER   = FVH + VBL;
  localparam int MASK  = (1 << PW) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        tinit = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [15:0] frame_cnt, frame_cnt2;
  logic        busy, busy2;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  csi2_test_pattern_gen_if #(.PIX_WIDTH(PW), .NUM_PIX_LANE(1)) pif ();
  csi2_test_pattern_gen_if #(.PIX_WIDTH(PW), .NUM_PIX_LANE(2)) pif2 ();

  csi2_test_pattern_gen #(
    .PIX_WIDTH(PW), .NUM_PIX_LANE(1), .H_ACTIVE(HA), .H_BLANK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_BACK(VBK), .V_BLANK(VBL)
  ) dut (
    .pix_clk_i(clk), .reset_n_i(rst_n), .enable_i(enable), .tinit_done_i(tinit),
    .pattern_i(pattern), .pix(pif), .frame_cnt_o(frame_cnt), .busy_o(busy)
  );

  csi2_test_pattern_gen #(
    .PIX_WIDTH(PW), .NUM_PIX_LANE(2), .H_ACTIVE(HA), .H_BLANK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_BACK(VBK), .V_BLANK(VBL)
  ) dut2 (
    .pix_clk_i(clk), .reset_n_i(rst_n), .enable_i(enable), .tinit_done_i(tinit),
    .pattern_i(pattern), .pix(pif2), .frame_cnt_o(frame_cnt2), .busy_o(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: frame activity and the cycle index within the current frame.
  int         m_active = 0;
  int         m_t = 0;
  int         m_pat = 0;
  int         m_fc = 0;
  logic [1:0] m_sync = 2'b00;

  always @(posedge clk or negedge rst_n) begin : ref_model
    bit go;
    if (!rst_n) begin
      m_active = 0; m_t = 0; m_pat = 0; m_fc = 0; m_sync = 2'b00;
    end else begin
      go = enable && m_sync[1];
      if (m_active == 0) begin
        if (go) begin m_active = 1; m_t = 0; m_pat = int'(pattern); end
      end else begin
        m_t++;
        if (m_t == FVH) m_fc = (m_fc + 1) % 65536;
        if (m_t == PER) begin
          if (go) begin m_t = 0; m_pat = int'(pattern); end
          else m_active = 0;
        end
      end
      m_sync = {m_sync[0], tinit};
    end
  end

  function automatic logic [31:0] exp_pix(input int lanes, input int x, input int y,
                                          input int p, input int f);
    logic [31:0] r;
    int v;
    r = '0;
    for (int k = 0; k < lanes; k++) begin
      case (p)
        0:       v = x*lanes + k;
        1:       v = y;
        2:       v = (x / (HA/8)) << (PW-3);
        default: v = ((((x >> 3) ^ (y >> 3) ^ f) & 1) != 0) ? MASK : 0;
      endcase
      r = r | (32'(v & MASK) << (k*PW));
    end
    return r;
  endfunction

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin : scoreboard
    int a, px, py;
    bit efv, elv;
    logic [31:0] ep1, ep2;
    efv = (m_active != 0) && (m_t < FVH);
    elv = 1'b0; px = 0; py = 0;
    if (efv && m_t >= VF) begin
      a = m_t - VF; py = a / LP; px = a % LP;
      elv = (py < VA) && (px < HA);
    end
    ep1 = elv ? exp_pix(1, px, py, m_pat, m_fc & 1) : 32'd0;
    ep2 = elv ? exp_pix(2, px, py, m_pat, m_fc & 1) : 32'd0;
    check_val("fv",        32'(pif.fv_o),      32'(efv));
    check_val("lv",        32'(pif.lv_o),      32'(elv));
    check_val("dvalid_eq", 32'(pif.dvalid_o),  32'(pif.lv_o));
    check_val("pixdata",   32'(pif.pixdata_o), ep1);
    check_val("frame_cnt", 32'(frame_cnt),     32'(m_fc));
    check_val("busy",      32'(busy),          32'(m_active));
    check_val("fv2",       32'(pif2.fv_o),     32'(efv));
    check_val("dvalid2_eq",32'(pif2.dvalid_o), 32'(pif2.lv_o));
    check_val("pixdata2",  32'(pif2.pixdata_o), ep2);
  end

  task automatic wait_fv(input logic val);
    int n = 0;
    while (pif.fv_o !== val && n < 400) begin @(negedge clk); n++; end
    if (pif.fv_o !== val) check_val("wait_fv", 32'(pif.fv_o), 32'(val));
  endtask

  task automatic wait_lv(input logic val);
    int n = 0;
    while (pif.lv_o !== val && n < 400) begin @(negedge clk); n++; end
    if (pif.lv_o !== val) check_val("wait_lv", 32'(pif.lv_o), 32'(val));
  endtask

  initial begin
    int n, r0, lr, t0, fc0;
    logic [19:0] p2;

    // Reset state.
    #1;
    check_val("rst_fv",  32'(pif.fv_o), 32'd0);
    check_val("rst_pix", 32'(pif.pixdata_o), 32'd0);
    check_val("rst_fc",  32'(frame_cnt), 32'd0);
    check_val("rst_busy",32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Enable without init-done: nothing may start.
    enable = 1'b1;
    repeat (100) @(negedge clk);
    check_val("hold_no_init", 32'(pif.fv_o), 32'd0);
    tinit = 1'b1;
    n = 0;
    while (pif.fv_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check_val("start_latency", 32'(n), 32'd3);
    r0 = cyc;

    // Frame geometry with the horizontal ramp.
    wait_lv(1'b1);
    check_val("lv_lead", 32'(cyc - r0), 32'(VF));
    lr = cyc;
    repeat (3) @(negedge clk);
    p2 = pif2.pixdata_o;
    check_val("lane0_x3", 32'(p2[9:0]), 32'd6);
    check_val("lane1_x3", 32'(p2[19:10]), 32'd7);
    wait_lv(1'b0);
    check_val("lv_len0", 32'(cyc - lr), 32'(HA));
    for (int i = 1; i < VA; i++) begin
      t0 = cyc;
      wait_lv(1'b1);
      check_val("hblank", 32'(cyc - t0), 32'(HB));
      lr = cyc;
      wait_lv(1'b0);
      check_val("lv_len", 32'(cyc - lr), 32'(HA));
    end
    wait_fv(1'b0);
    check_val("fv_high", 32'(cyc - r0), 32'd61);
    check_val("fc_step1", 32'(frame_cnt), 32'd1);
    wait_fv(1'b1);
    check_val("period", 32'(cyc - r0), 32'd66);

    // Pattern change mid-frame is held off until the next frame.
    pattern = 2'd2;
    wait_lv(1'b1);
    @(negedge clk);
    check_val("pat_hold", 32'(pif.pixdata_o), 32'd1);
    wait_fv(1'b0);
    check_val("fc_step2", 32'(frame_cnt), 32'd2);
    wait_fv(1'b1);
    pattern = 2'd1;
    wait_lv(1'b1);
    for (int i = 0; i < HA; i++) begin
      check_val("bars", 32'(pif.pixdata_o), 32'((i / 2) << 7));
      @(negedge clk);
    end

    // Randomized enable, init-done and pattern against the model.
    for (int i = 0; i < 1500; i++) begin
      enable  = ($urandom_range(0, 99) < 90);
      tinit   = ($urandom_range(0, 99) < 95);
      pattern = 2'($urandom_range(0, 3));
      @(negedge clk);
    end

    // Enable dropped during line 1: frame completes, then idle.
    enable = 1'b1; tinit = 1'b1; pattern = 2'd3;
    wait_fv(1'b0);
    wait_fv(1'b1);
    r0 = cyc;
    fc0 = int'(frame_cnt);
    wait_lv(1'b1);
    wait_lv(1'b0);
    wait_lv(1'b1);
    enable = 1'b0;
    wait_fv(1'b0);
    check_val("drop_fv_high", 32'(cyc - r0), 32'd61);
    check_val("drop_fc", 32'(frame_cnt), 32'((fc0 + 1) % 65536));
    repeat (VBL - 1) @(negedge clk);
    check_val("vblank_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_val("idle_busy", 32'(busy), 32'd0);

    // Reset asserted during line 2.
    enable = 1'b1;
    wait_fv(1'b1);
    wait_lv(1'b1); wait_lv(1'b0);
    wait_lv(1'b1); wait_lv(1'b0);
    wait_lv(1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("mrst_fv",  32'(pif.fv_o), 32'd0);
    check_val("mrst_lv",  32'(pif.lv_o), 32'd0);
    check_val("mrst_dv",  32'(pif.dvalid_o), 32'd0);
    check_val("mrst_pix", 32'(pif.pixdata_o), 32'd0);
    check_val("mrst_fc",  32'(frame_cnt), 32'd0);
    check_val("mrst_busy",32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_fv(1'b1);
    r0 = cyc;
    check_val("post_rst_fc0", 32'(frame_cnt), 32'd0);
    wait_fv(1'b0);
    check_val("post_rst_high", 32'(cyc - r0), 32'd61);
    check_val("post_rst_fc1", 32'(frame_cnt), 32'd1);
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/csi2_test_pattern_gen.md
# csi2_test_pattern_gen

Frame-timing sequencer and test-pattern source for the CSI-2 transmit path. It drives the pixel-side inputs of the pixel-to-byte converter (`fv`, `lv`, `dvalid`, pixel data) in place of a camera sensor. It holds off until the D-PHY reports init done, then emits complete frames with programmable active size, blanking and pattern. It lives in the `pix_clk_i` domain, in front of the pixel-to-byte converter, in the test-screen build.

## Interface
Parameters:
- `PIX_WIDTH`, 10: bits per pixel.
- `NUM_PIX_LANE`, 1: pixels per clock; `pixdata_o` is `PIX_WIDTH*NUM_PIX_LANE` bits wide.
- `H_ACTIVE`, 160: active cycles per line. Must be a multiple of 8 and at least 8.
- `H_BLANK`, 40: `lv` low cycles between lines. Must be at least 1.
- `V_ACTIVE`, 120: lines per frame. Must be at least 1.
- `V_FRONT`, 16: cycles from the `fv` rise to the first `lv` rise. Must be at least 1.
- `V_BACK`, 16: cycles from the last `lv` fall to the `fv` fall. Must be at least 1.
- `V_BLANK`, 64: minimum `fv` low cycles between frames. Must be at least 1.

Ports (clock and reset first):
- `pix_clk_i`, in, 1: the single clock.
- `reset_n_i`, in, 1: asynchronous, active-low reset.
- `enable_i`, in, 1: frame generation request, level-sensitive.
- `tinit_done_i`, in, 1: D-PHY init done. Asynchronous; synchronized internally by 2 flops.
- `pattern_i`, in, 2: pattern select, sampled once per frame.
- `fv_o`, out, 1: frame valid.
- `lv_o`, out, 1: line valid.
- `dvalid_o`, out, 1: data valid; always equal to `lv_o`.
- `pixdata_o`, out, `PIX_WIDTH*NUM_PIX_LANE`: pixel data. Lane k occupies bits `[(k+1)*PIX_WIDTH-1 : k*PIX_WIDTH]`.
- `frame_cnt_o`, out, 16: number of completed frames.
- `busy_o`, out, 1: high whenever the state is not IDLE.

## Operation
- Define `rdy` as the synchronized `tinit_done_i`.
- States and transitions:
  - IDLE: `fv=0`. When `enable_i & rdy`, go to FV_LEAD.
  - FV_LEAD: `fv=1`. Stay `V_FRONT` cycles, then go to LINE.
  - LINE: `fv=lv=dvalid=1`. Stay `H_ACTIVE` cycles, then:
    - go to HBLANK if this is not the last line;
    - go to FV_TRAIL if it is the last line (no HBLANK follows the last line).
  - HBLANK: `fv=1`, `lv=0`. Stay `H_BLANK` cycles, then go to LINE.
  - FV_TRAIL: `fv=1`, `lv=0`. Stay `V_BACK` cycles, then go to VBLANK.
  - VBLANK: `fv=0`. Stay `V_BLANK` cycles, then:
    - go to FV_LEAD if `enable_i & rdy`;
    - otherwise go to IDLE.
- `enable_i` or `rdy` falling mid-frame has no effect until the frame ends. A frame is never truncated.
- Counters:
  - x: cycle index within the line, 0..`H_ACTIVE`-1.
  - y: line index, 0..`V_ACTIVE`-1.
  - State-duration counter: sized for the largest parameter.
- `pattern_i` is latched on entry to FV_LEAD and held for the whole frame.
- Pixel value for lane k at cycle x, line y. Results are truncated to `PIX_WIDTH` bits.
  - 0, horizontal ramp: `x*NUM_PIX_LANE + k`.
  - 1, vertical ramp: `y`, the same value on all lanes.
  - 2, color bars: `bar << (PIX_WIDTH-3)`, where `bar = x / (H_ACTIVE/8)` (0..7), the same value on all lanes.
    - Implement `bar` with a running sub-counter; no divider.
  - 3, checkerboard: all ones if `x[3] ^ y[3] ^ frame_cnt_o[0]`, otherwise zero.
- `pixdata_o` is 0 whenever `dvalid_o` is 0.
- `frame_cnt_o` increments (wrapping at 16 bits) in the cycle `fv_o` falls.

## Timing
- All outputs are registered.
- Reset values: `fv_o`, `lv_o`, `dvalid_o`, `pixdata_o`, `frame_cnt_o` and `busy_o` are all 0; the state is IDLE.
- `tinit_done_i` to `rdy` latency: 2 cycles.
- Start latency: `enable_i & rdy` true at edge N makes `fv_o` and `busy_o` high after edge N+1.
- `fv_o` high duration: `V_FRONT + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + V_BACK` cycles.
- Frame period under continuous enable: the `fv_o` high duration plus `V_BLANK`.
- The first `lv_o` rise comes exactly `V_FRONT` cycles after the `fv_o` rise.
- `lv_o` is high for exactly `H_ACTIVE` consecutive cycles per line.
- `pixdata_o` is aligned with `dvalid_o` in the same cycle.
- Reset asserted mid-frame: all outputs drop to 0 asynchronously. After release the block restarts from IDLE, with no partial frame and `frame_cnt_o`=0.

## Test plan
Bench parameters for scenarios 1–5: `H_ACTIVE`=16, `H_BLANK`=4, `V_ACTIVE`=3, `V_FRONT`=2, `V_BACK`=3, `V_BLANK`=5, `PIX_WIDTH`=10, `NUM_PIX_LANE`=1. This gives `fv` high = 61 cycles and a frame period of 66 cycles.

1. `enable_i`=1 with `tinit_done_i`=0 for 100 cycles, then `tinit_done_i`=1. Required: `fv_o` stays 0 until the rise, then rises 3 cycles after it (2-flop sync plus 1).
2. Continuous enable, `pattern_i`=0:
   - `fv_o` high 61 cycles, period 66;
   - three `lv_o` pulses of 16 cycles separated by 4 cycles;
   - first `lv_o` rise 2 cycles after the `fv_o` rise;
   - `pixdata_o` runs 0..15 on each line;
   - `frame_cnt_o` steps 0→1→2.
3. `pattern_i`=2. Required: `pixdata_o` follows 0,0,128,128,256,256 … 896,896. Change `pattern_i` mid-frame: the change takes effect only from the next frame.
4. Drop `enable_i` during line 1. Required: the current frame completes (61 cycles high), then the block returns to IDLE with `busy_o`=0 after `V_BLANK`. `frame_cnt_o` is incremented by 1.
5. Assert reset during line 2. Required: all outputs are 0 immediately. After release and enable, a full 61-cycle frame follows with `frame_cnt_o` counting from 0.
6. `NUM_PIX_LANE`=2, `pattern_i`=0. Required: at x=3, lane0=6 and lane1=7. Also assert `dvalid_o`==`lv_o` on every cycle.
